// File: rtl/product_pkg.sv
// Shared types and constants for the mantissa product stage.
// - MANT_W / PROD_W : operand and product widths
// - STAGES          : fixed pipeline depth (operand sample -> registered sum)
// - rows_at()       : rows remaining after a given number of 3:2 tree levels
// - tree_levels()   : number of 3:2 levels needed to reach two rows
package product_pkg;

  localparam int MANT_W = 24;
  localparam int PROD_W = 2 * MANT_W;
  localparam int STAGES = 2;

  typedef logic [MANT_W-1:0] mant_t;
  typedef logic [PROD_W-1:0] prod_t;

  // Each level turns every full group of three rows into two and passes
  // any leftover rows straight through.
  function automatic int rows_at(input int lvl);
    int n;
    n = MANT_W;
    for (int i = 0; i < lvl; i++) n = (n / 3) * 2 + (n % 3);
    return n;
  endfunction

  function automatic int tree_levels();
    int n;
    int l;
    n = MANT_W;
    l = 0;
    while (n > 2) begin
      n = (n / 3) * 2 + (n % 3);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/product_csa_3to2.sv
// Carry-save 3:2 compressor, bitwise over W bits.
// - a, b, c : three addends
// - s       : a ^ b ^ c
// - cy      : majority(a, b, c) shifted up one bit; the carry out of the MSB
//             is dropped, which is exact because the full product fits in W bits
module csa_3to2 #(
  parameter int W = 48
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] cy
);

  assign s  = a ^ b ^ c;
  assign cy = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/product.sv
// Unsigned 24x24 -> 48-bit pipelined mantissa multiplier (significand product
// of the FP multiply datapath). One operand pair per clock, result two clocks
// later, no rounding or normalisation.
// - clk       : rising-edge clock
// - rst       : synchronous, active-high; clears every pipeline register
// - in_valid  : qualifies min/q this cycle (only steers out_valid)
// - min, q    : multiplicand / multiplier, hidden bit included
// - out_valid : sum holds a valid product
// - sum       : min*q from two clocks earlier, registered
module product
  import product_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [MANT_W-1:0] min,
  input  logic [MANT_W-1:0] q,
  output logic              out_valid,
  output logic [PROD_W-1:0] sum
);

  localparam int WIDTH   = MANT_W;
  localparam int LATENCY = STAGES;
  localparam int LVLS    = tree_levels();

  // tree[l][r] is row r after l compressor levels; rows beyond the live count
  // at each level are tied to zero so every element has exactly one driver.
  prod_t tree [0:LVLS][0:WIDTH-1];

  for (genvar r = 0; r < WIDTH; r++) begin : g_pp
    assign tree[0][r] = {{WIDTH{1'b0}}, min & {WIDTH{q[r]}}} << r;
  end

  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    localparam int N = rows_at(l);
    localparam int M = rows_at(l + 1);
    localparam int G = N / 3;

    for (genvar g = 0; g < G; g++) begin : g_csa
      csa_3to2 #(.W(PROD_W)) u_csa (
        .a  (tree[l][3*g]),
        .b  (tree[l][3*g+1]),
        .c  (tree[l][3*g+2]),
        .s  (tree[l+1][2*g]),
        .cy (tree[l+1][2*g+1])
      );
    end

    for (genvar r = 0; r < N % 3; r++) begin : g_pass
      assign tree[l+1][2*G+r] = tree[l][3*G+r];
    end

    for (genvar r = M; r < WIDTH; r++) begin : g_zero
      assign tree[l+1][r] = '0;
    end
  end

  prod_t              s_q, c_q;
  logic [LATENCY:1]   vld_pipe;

  // Operands are multiplied unconditionally; in_valid only rides alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q      <= '0;
      c_q      <= '0;
      sum      <= '0;
      vld_pipe <= '0;
    end else begin
      s_q      <= tree[LVLS][0];
      c_q      <= tree[LVLS][1];
      sum      <= s_q + c_q;
      vld_pipe <= {vld_pipe[LATENCY-1:1], in_valid};
    end
  end

  assign out_valid = vld_pipe[LATENCY];

endmodule

// File: tb/tb_product.sv
// Self-checking bench for product. Each cycle the driver pushes the expected
// {valid, product} for the pair it presents; the checker pops one entry per
// cycle, two clocks later, and compares against sum/out_valid.
module tb_product;
  import product_pkg::*;

  typedef struct packed {
    logic  v;
    prod_t p;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  in_valid;
  mant_t min, q;
  logic  out_valid;
  prod_t sum;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  product dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .min       (min),
    .q         (q),
    .out_valid (out_valid),
    .sum       (sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, record its expectation, then at the next falling edge
  // compare the output that belongs to the pair driven two cycles back.
  task automatic step(input string tag, input logic r, input logic v,
                      input mant_t a, input mant_t b, input prod_t ep);
    exp_t e;
    rst      = r;
    in_valid = v;
    min      = a;
    q        = b;
    if (r) begin
      // Reset clears both stages: the entry still in flight is also zero.
      foreach (sb[i]) sb[i] = '0;
      e = '0;
    end else begin
      e.v = v;
      e.p = ep;
    end
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_sum"}, 64'(sum), 64'(e.p));
      check({tag, "_vld"}, 64'(out_valid), 64'(e.v));
    end
  endtask

  task automatic send(input string tag, input logic v, input mant_t a, input mant_t b,
                      input prod_t ep);
    step(tag, 1'b0, v, a, b, ep);
  endtask

  function automatic prod_t mul(input mant_t a, input mant_t b);
    prod_t pa, pb;
    pa = prod_t'(a);
    pb = prod_t'(b);
    return pa * pb;
  endfunction

  initial begin
    mant_t a, b;
    logic  v;
    // Output after the very first (reset) edge is zero.
    sb.push_back('0);

    // Reset with random operands and in_valid high.
    for (int i = 0; i < 2; i++)
      step("rst", 1'b1, 1'b1, mant_t'($urandom), mant_t'($urandom), '0);
    // Idle, non-valid operands: products flow but out_valid stays low.
    send("idle", 1'b0, 24'h000000, 24'h000000, 48'h0);

    // Patterns back-to-back, then flush.
    send("pat1", 1'b1, 24'hCCCCCC, 24'hAAAAAA, 48'h888887777778);
    send("pat2", 1'b1, 24'h555555, 24'hCCCCCC, 48'h444443BBBBBC);
    send("pat1d", 1'b1, 24'hCCCCCC, 24'hAAAAAA, 48'd150119969683320);
    send("pat2d", 1'b1, 24'h555555, 24'hCCCCCC, 48'd75059984841660);

    // Corners.
    send("max",  1'b1, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
    send("zero", 1'b1, 24'h000000, 24'hABCDEF, 48'h0);
    send("zerb", 1'b1, 24'hABCDEF, 24'h000000, 48'h0);
    send("msb",  1'b1, 24'h800000, 24'h800000, 48'h400000000000);
    send("one",  1'b1, 24'h000001, 24'h123456, 48'h000000123456);
    send("nov",  1'b0, 24'h000003, 24'h000005, 48'h00000000000F);

    // Reset mid-stream: the valid pair in flight must vanish.
    send("mid", 1'b1, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
    step("midrst", 1'b1, 1'b1, 24'h123456, 24'h654321, '0);
    send("post", 1'b0, 24'h000002, 24'h000002, 48'h4);
    send("post2", 1'b1, 24'h000007, 24'h000006, 48'h2A);

    // Random traffic with in_valid toggling.
    for (int i = 0; i < 10000; i++) begin
      a = mant_t'($urandom);
      b = mant_t'($urandom);
      v = 1'($urandom_range(0, 1));
      send("rnd", v, a, b, mul(a, b));
    end

    // Drain the last two entries.
    send("drain", 1'b0, 24'h0, 24'h0, 48'h0);
    send("drain", 1'b0, 24'h0, 24'h0, 48'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
